// File: rtl/dz_scan_monitor_if.sv
// Scan-side and readout-side signal bundle for the dot-matrix scan monitor.
// The master drives the scan strobes and read address; the slave is the monitor.
interface dz_scan_monitor_if;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic [2:0] rd_addr;
  logic       err_clr;
  logic [7:0] rd_red;
  logic [7:0] rd_green;
  logic       frame_valid;
  logic       frame_pulse;
  logic       frame_changed;
  logic [7:0] frame_cnt;
  logic       multi_err;
  logic       scan_lost;

  modport master (
    output row, colr, colg, rd_addr, err_clr,
    input  rd_red, rd_green, frame_valid, frame_pulse, frame_changed,
           frame_cnt, multi_err, scan_lost
  );

  modport slave (
    input  row, colr, colg, rd_addr, err_clr,
    output rd_red, rd_green, frame_valid, frame_pulse, frame_changed,
           frame_cnt, multi_err, scan_lost
  );
endinterface

// File: rtl/dz_scan_monitor.sv
// Rebuilds red/green 8x8 frames from a multiplexed row/column scan and exposes
// the last complete frame through a registered read port with status flags.
module dz_scan_monitor #(
  parameter int MIN_HOLD = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  dz_scan_monitor_if.slave   bus
);

  localparam logic [3:0] HOLD_CAP = 4'(MIN_HOLD - 2);
  localparam logic [3:0] HOLD_MAX = 4'(MIN_HOLD);
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [9:0] TO_MAX   = 10'(TIMEOUT);

  logic [7:0] row_p0, row_p1, row_p2;
  logic [7:0] colr_p0, colr_p1, colr_p2;
  logic [7:0] colg_p0, colg_p1, colg_p2;

  logic [3:0] hold_cnt;
  logic [9:0] idle_cnt;
  logic [7:0] seen;
  logic [7:0][7:0] shadow_r, shadow_g, vis_r, vis_g;
  logic [7:0][7:0] shadow_nxt_r, shadow_nxt_g;
  logic [7:0] seen_nxt, sel_n;
  logic [2:0] idx;
  logic       stable, row_idle, row_one, illegal, capture, commit, timeout_hit;

  logic [7:0] rd_red, rd_green, frame_cnt;
  logic       frame_valid, frame_pulse, frame_changed, multi_err, scan_lost;

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised tuple
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0  <= '1;
      row_p1  <= '1;
      row_p2  <= '1;
      colr_p0 <= '0;
      colr_p1 <= '0;
      colr_p2 <= '0;
      colg_p0 <= '0;
      colg_p1 <= '0;
      colg_p2 <= '0;
    end else begin
      row_p0  <= bus.row;
      row_p1  <= row_p0;
      row_p2  <= row_p1;
      colr_p0 <= bus.colr;
      colr_p1 <= colr_p0;
      colr_p2 <= colr_p1;
      colg_p0 <= bus.colg;
      colg_p1 <= colg_p0;
      colg_p2 <= colg_p1;
    end
  end

  // Classification of the synchronised tuple and the capture/commit decision
  always_comb begin
    stable   = (row_p1 == row_p2) && (colr_p1 == colr_p2) && (colg_p1 == colg_p2);
    sel_n    = ~row_p1;
    row_idle = (row_p1 == 8'hFF);
    row_one  = !row_idle && ((sel_n & (sel_n - 8'd1)) == 8'd0);
    illegal  = !row_idle && !row_one;
    idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!row_p1[i]) idx = 3'(i);
    end
    capture      = stable && row_one && (hold_cnt == HOLD_CAP);
    shadow_nxt_r = shadow_r;
    shadow_nxt_g = shadow_g;
    shadow_nxt_r[idx] = colr_p1;
    shadow_nxt_g[idx] = colg_p1;
    seen_nxt     = seen | (8'd1 << idx);
    commit       = capture && (seen_nxt == 8'hFF);
    timeout_hit  = !capture && (idle_cnt == TO_LAST);
  end

  // Frame assembly, commit, timeout and registered readout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt      <= '0;
      idle_cnt      <= '0;
      seen          <= '0;
      shadow_r      <= '0;
      shadow_g      <= '0;
      vis_r         <= '0;
      vis_g         <= '0;
      frame_valid   <= 1'b0;
      frame_pulse   <= 1'b0;
      frame_changed <= 1'b0;
      frame_cnt     <= '0;
      multi_err     <= 1'b0;
      scan_lost     <= 1'b0;
      rd_red        <= '0;
      rd_green      <= '0;
    end else begin
      frame_pulse   <= 1'b0;
      frame_changed <= 1'b0;

      if (!stable || illegal)      hold_cnt <= '0;
      else if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 4'd1;

      // An illegal tuple in the same cycle as err_clr keeps the flag set
      if (illegal)          multi_err <= 1'b1;
      else if (bus.err_clr) multi_err <= 1'b0;

      if (capture) begin
        shadow_r  <= shadow_nxt_r;
        shadow_g  <= shadow_nxt_g;
        seen      <= seen_nxt;
        idle_cnt  <= '0;
        scan_lost <= 1'b0;
        if (commit) begin
          vis_r         <= shadow_nxt_r;
          vis_g         <= shadow_nxt_g;
          seen          <= '0;
          frame_pulse   <= 1'b1;
          frame_changed <= !frame_valid ||
                           ({shadow_nxt_r, shadow_nxt_g} != {vis_r, vis_g});
          frame_valid   <= 1'b1;
          frame_cnt     <= frame_cnt + 8'd1;
        end
      end else begin
        if (idle_cnt < TO_MAX) idle_cnt <= idle_cnt + 10'd1;
        if (timeout_hit) begin
          scan_lost   <= 1'b1;
          seen        <= '0;
          frame_valid <= 1'b0;
        end
      end

      rd_red   <= vis_r[bus.rd_addr];
      rd_green <= vis_g[bus.rd_addr];
    end
  end

  assign bus.rd_red        = rd_red;
  assign bus.rd_green      = rd_green;
  assign bus.frame_valid   = frame_valid;
  assign bus.frame_pulse   = frame_pulse;
  assign bus.frame_changed = frame_changed;
  assign bus.frame_cnt     = frame_cnt;
  assign bus.multi_err     = multi_err;
  assign bus.scan_lost     = scan_lost;

endmodule

// File: tb/tb_dz_scan_monitor.sv
// Directed bench for dz_scan_monitor: table of whole frames plus sequences for
// short holds, timeout, multi-row errors, counter wrap and asynchronous reset.
module tb_dz_scan_monitor;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   pulse_cnt;
  logic last_chg;

  dz_scan_monitor_if bus ();

  dz_scan_monitor #(.MIN_HOLD(4), .TIMEOUT(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_pulse) begin
      pulse_cnt++;
      last_chg = bus.frame_changed;
    end
  end

  typedef struct {
    logic [7:0] red;
    logic [7:0] g3;
    logic       exp_chg;
    logic [7:0] exp_cnt;
  } frame_vec_t;

  frame_vec_t vecs [5];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic scan_row(input int idx, input logic [7:0] r, input logic [7:0] g, input int hold);
    bus.row  = ~(8'd1 << idx);
    bus.colr = r;
    bus.colg = g;
    tick(hold);
  endtask

  task automatic go_idle(input int n);
    bus.row  = 8'hFF;
    bus.colr = 8'h00;
    bus.colg = 8'h00;
    tick(n);
  endtask

  task automatic scan_frame(input logic [7:0] red, input logic [7:0] g3, input int hold);
    for (int i = 0; i < 8; i++) scan_row(i, red, (i == 3) ? g3 : 8'h00, hold);
    go_idle(8);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] red, input logic [7:0] g3);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      tick(1);
      check({tag, "_rd_red"}, {24'd0, bus.rd_red}, {24'd0, red});
      check({tag, "_rd_green"}, {24'd0, bus.rd_green}, (a == 3) ? {24'd0, g3} : 32'd0);
    end
  endtask

  task automatic wait_lost(output int waited);
    waited = 0;
    while (!bus.scan_lost && waited < 1200) begin
      tick(1);
      waited++;
    end
  endtask

  initial begin
    int p0;
    int waited;
    int n;

    tests = 0;
    fails = 0;
    pulse_cnt = 0;
    last_chg = 1'b0;

    vecs[0] = '{red: 8'h18, g3: 8'h00, exp_chg: 1'b1, exp_cnt: 8'd1};
    vecs[1] = '{red: 8'h18, g3: 8'h00, exp_chg: 1'b0, exp_cnt: 8'd2};
    vecs[2] = '{red: 8'h18, g3: 8'hFF, exp_chg: 1'b1, exp_cnt: 8'd3};
    vecs[3] = '{red: 8'h81, g3: 8'hFF, exp_chg: 1'b1, exp_cnt: 8'd4};
    vecs[4] = '{red: 8'h81, g3: 8'hFF, exp_chg: 1'b0, exp_cnt: 8'd5};

    rst = 1'b1;
    bus.row = 8'hFF;
    bus.colr = 8'h00;
    bus.colg = 8'h00;
    bus.rd_addr = 3'd0;
    bus.err_clr = 1'b0;
    tick(3);
    check("rst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_multi_err", {31'd0, bus.multi_err}, 32'd0);
    check("rst_scan_lost", {31'd0, bus.scan_lost}, 32'd0);
    check("rst_rd_red", {24'd0, bus.rd_red}, 32'd0);
    rst = 1'b0;
    tick(3);

    // Frame table: one pulse per complete scan, changed flag, counter and contents
    for (int v = 0; v < 5; v++) begin
      p0 = pulse_cnt;
      scan_frame(vecs[v].red, vecs[v].g3, 10);
      check("tbl_pulses", pulse_cnt - p0, 32'd1);
      check("tbl_changed", {31'd0, last_chg}, {31'd0, vecs[v].exp_chg});
      check("tbl_frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, vecs[v].exp_cnt});
      check("tbl_frame_valid", {31'd0, bus.frame_valid}, 32'd1);
      check_frame("tbl", vecs[v].red, vecs[v].g3);
    end

    // Rows held for only MIN_HOLD-1 cycles are never captured
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) scan_row(i, 8'hA5, 8'h5A, 3);
    go_idle(8);
    check("short_no_pulse", pulse_cnt - p0, 32'd0);
    check("short_not_lost_yet", {31'd0, bus.scan_lost}, 32'd0);
    wait_lost(waited);
    check("short_scan_lost", {31'd0, bus.scan_lost}, 32'd1);
    check("short_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("short_cnt_kept", {24'd0, bus.frame_cnt}, 32'd5);
    check_frame("kept", 8'h81, 8'hFF);

    // Two rows at once: sticky error, set beats clear, clear after idle
    p0 = pulse_cnt;
    bus.row = 8'hFC;
    bus.colr = 8'hFF;
    tick(10);
    check("multi_set", {31'd0, bus.multi_err}, 32'd1);
    bus.err_clr = 1'b1;
    tick(3);
    check("multi_set_wins", {31'd0, bus.multi_err}, 32'd1);
    bus.err_clr = 1'b0;
    go_idle(5);
    check("multi_sticky", {31'd0, bus.multi_err}, 32'd1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("multi_cleared", {31'd0, bus.multi_err}, 32'd0);
    check("multi_no_pulse", pulse_cnt - p0, 32'd0);

    // Partial scan is discarded by the timeout; next full scan commits once
    p0 = pulse_cnt;
    scan_row(7, 8'h3C, 8'h00, 10);
    scan_row(0, 8'h3C, 8'h00, 10);
    scan_row(5, 8'h3C, 8'h00, 10);
    scan_row(2, 8'h3C, 8'h00, 10);
    scan_row(6, 8'h3C, 8'h00, 10);
    scan_row(1, 8'h3C, 8'h00, 10);
    scan_row(4, 8'h3C, 8'h00, 10);
    go_idle(1);
    check("part_lost_cleared", {31'd0, bus.scan_lost}, 32'd0);
    check("part_no_pulse", pulse_cnt - p0, 32'd0);
    wait_lost(waited);
    check("part_scan_lost", {31'd0, bus.scan_lost}, 32'd1);
    check("part_timeout_window", {31'd0, (waited >= 980 && waited <= 1000)}, 32'd1);
    scan_row(0, 8'h81, 8'h00, 10);
    check("part_lost_clears", {31'd0, bus.scan_lost}, 32'd0);
    for (int i = 1; i < 8; i++) scan_row(i, 8'h81, (i == 3) ? 8'hFF : 8'h00, 10);
    go_idle(8);
    check("part_one_pulse", pulse_cnt - p0, 32'd1);
    check("part_changed_after_loss", {31'd0, last_chg}, 32'd1);
    check("part_frame_cnt", {24'd0, bus.frame_cnt}, 32'd6);
    check("part_frame_valid", {31'd0, bus.frame_valid}, 32'd1);
    check_frame("part", 8'h81, 8'hFF);

    // Counter wrap over identical frames
    n = 0;
    while (bus.frame_cnt != 8'd255 && n < 300) begin
      scan_frame(8'h81, 8'hFF, 6);
      n++;
    end
    check("wrap_frames_to_255", n, 32'd249);
    check("wrap_cnt_255", {24'd0, bus.frame_cnt}, 32'd255);
    scan_frame(8'h81, 8'hFF, 6);
    check("wrap_cnt_0", {24'd0, bus.frame_cnt}, 32'd0);
    check("wrap_unchanged", {31'd0, last_chg}, 32'd0);

    // Asynchronous reset in the middle of a scan
    for (int i = 0; i < 4; i++) scan_row(i, 8'h55, 8'h00, 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("arst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("arst_rd_red", {24'd0, bus.rd_red}, 32'd0);
    check("arst_rd_green", {24'd0, bus.rd_green}, 32'd0);
    tick(2);
    bus.row = 8'hFF;
    bus.colr = 8'h00;
    rst = 1'b0;
    tick(3);
    p0 = pulse_cnt;
    scan_frame(8'h0F, 8'h00, 10);
    check("arst_one_pulse", pulse_cnt - p0, 32'd1);
    check("arst_cnt_1", {24'd0, bus.frame_cnt}, 32'd1);
    check("arst_changed", {31'd0, last_chg}, 32'd1);
    check_frame("arst", 8'h0F, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
